// File: rtl/data_sram_resp.sv
// Data SRAM port responder for MiniMIPS32: word RAM plus LED/counter/compare MMIO window.
// Optional timer interrupt is built when DATA_SRAM_RESP_TIMER_IRQ_EN is defined.
module data_sram_resp #(
  parameter int          ADDR_W  = 14,
  parameter logic [15:0] MMIO_HI = 16'hBFAF
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        dce,
  input  logic [3:0]  we,
  input  logic [31:0] daddr,
  input  logic [31:0] din,
  output logic [31:0] dm,
  output logic [15:0] led,
  output logic        timer_int
);

  localparam logic [15:0] OFF_LED     = 16'hF000;
  localparam logic [15:0] OFF_COUNTER = 16'hE000;
  localparam logic [15:0] OFF_COMPARE = 16'hE004;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic              is_mmio;
  logic [15:0]       offset;
  logic [ADDR_W-1:0] widx;
  logic              rd_en;
  logic              ram_wr;
  logic              mmio_wr;
  logic              led_wr;
  logic              cnt_wr;
  logic [31:0]       counter;
  logic [31:0]       mmio_rdata;

  assign is_mmio = (daddr[31:16] == MMIO_HI);
  assign offset  = daddr[15:0];
  assign widx    = daddr[ADDR_W+1:2];
  assign rd_en   = dce && (we == 4'h0);
  assign ram_wr  = dce && (|we) && !is_mmio;
  // MMIO registers only accept full-word stores.
  assign mmio_wr = dce && (we == 4'hF) && is_mmio;
  assign led_wr  = mmio_wr && (offset == OFF_LED);
  assign cnt_wr  = mmio_wr && (offset == OFF_COUNTER);

  // RAM is not reset, so it lives in its own clocked block.
  always_ff @(posedge cpu_clk_50M) begin
    if (ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[widx][8*i +: 8] <= din[8*i +: 8];
      end
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      counter <= '0;
      led     <= '0;
    end else begin
      counter <= cnt_wr ? din : counter + 32'd1;
      if (led_wr) led <= din[15:0];
    end
  end

`ifdef DATA_SRAM_RESP_TIMER_IRQ_EN
  logic [31:0] compare;
  logic        cmp_wr;

  assign cmp_wr = mmio_wr && (offset == OFF_COMPARE);

  // A COMPARE store clears the interrupt even if a match happens that cycle.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      compare   <= '0;
      timer_int <= 1'b0;
    end else begin
      if (cmp_wr) begin
        compare   <= din;
        timer_int <= 1'b0;
      end else if ((counter == compare) && (compare != 32'd0)) begin
        timer_int <= 1'b1;
      end
    end
  end
`else
  assign timer_int = 1'b0;
`endif

  always_comb begin
    mmio_rdata = 32'd0;
    case (offset)
      OFF_LED:     mmio_rdata = {16'd0, led};
      OFF_COUNTER: mmio_rdata = counter;
`ifdef DATA_SRAM_RESP_TIMER_IRQ_EN
      OFF_COMPARE: mmio_rdata = compare;
`endif
      default:     mmio_rdata = 32'd0;
    endcase
  end

  // dm only moves on a read, so the core can sample it any time afterwards.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      dm <= '0;
    end else if (rd_en) begin
      dm <= is_mmio ? mmio_rdata : mem[widx];
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: vector table fed through a read scoreboard, plus reset and timer sequences.
// Timer expectations follow DATA_SRAM_RESP_TIMER_IRQ_EN when it is defined.
module tb_data_sram_resp;

  logic        clk;
  logic        rst_n;
  logic        dce;
  logic [3:0]  we;
  logic [31:0] daddr;
  logic [31:0] din;
  logic [31:0] dm;
  logic [15:0] led;
  logic        timer_int;
  logic        sb_expect;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic        dce;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  data_sram_resp dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (rst_n),
    .dce         (dce),
    .we          (we),
    .daddr       (daddr),
    .din         (din),
    .dm          (dm),
    .led         (led),
    .timer_int   (timer_int)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic add_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    vecs.push_back('{1'b1, w, a, d, 32'd0});
  endtask

  task automatic add_w_nodce(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    vecs.push_back('{1'b0, w, a, d, 32'd0});
  endtask

  task automatic add_r(input logic [31:0] a, input logic [31:0] e);
    vecs.push_back('{1'b1, 4'h0, a, 32'd0, e});
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    dce       = v.dce;
    we        = v.we;
    daddr     = v.addr;
    din       = v.din;
    sb_expect = v.dce && (v.we == 4'h0);
    if (sb_expect) exp_q.push_back(v.exp);
  endtask

  task automatic idle();
    @(negedge clk);
    dce       = 1'b0;
    we        = 4'h0;
    sb_expect = 1'b0;
  endtask

  task automatic mmio_write(input logic [15:0] off, input logic [31:0] d);
    @(negedge clk);
    dce       = 1'b1;
    we        = 4'hF;
    daddr     = {16'hBFAF, off};
    din       = d;
    sb_expect = 1'b0;
  endtask

  // scoreboard: every flagged read is compared one edge later
  always @(posedge clk) begin
    if (rst_n && dce && (we == 4'h0) && sb_expect) begin
      #1;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got read with empty queue, required queued value");
      end else begin
        check("sb_read", dm, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] d1;
    logic [31:0] d2;
    logic        irq_exp;

    rst_n     = 1'b0;
    dce       = 1'b0;
    we        = 4'h0;
    daddr     = 32'd0;
    din       = 32'd0;
    sb_expect = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_dm", dm, 32'd0);
    check("reset_led", {16'd0, led}, 32'd0);
    check("reset_timer_int", {31'd0, timer_int}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back counter reads differ by one
    @(negedge clk);
    dce   = 1'b1;
    we    = 4'h0;
    daddr = 32'hBFAF_E000;
    @(posedge clk);
    #1 d1 = dm;
    @(posedge clk);
    #1 d2 = dm;
    idle();
    check("counter_step", d2 - d1, 32'd1);

    // vector table
    add_w(32'h0000_0010, 32'h1122_3344, 4'hF);
    add_w(32'h0000_0010, 32'hAA00_0000, 4'h8);
    add_r(32'h0000_0010, 32'hAA22_3344);
    add_w(32'h0000_0040, 32'hDEAD_BEEF, 4'hF);
    add_r(32'h0000_0040, 32'hDEAD_BEEF);
    add_w(32'hBFAF_F000, 32'h0001_A5A5, 4'hF);
    add_w(32'hBFAF_F000, 32'h0000_FFFF, 4'h1);
    add_r(32'hBFAF_F000, 32'h0000_A5A5);
    add_w(32'hBFAF_E000, 32'hFFFF_FFFE, 4'hF);
    add_r(32'hBFAF_E000, 32'hFFFF_FFFE);
    add_r(32'hBFAF_E000, 32'hFFFF_FFFF);
    add_r(32'hBFAF_E000, 32'h0000_0000);
    add_r(32'h0001_0010, 32'hAA22_3344);
    add_w_nodce(32'h0000_0010, 32'h0000_0000, 4'hF);
    add_r(32'h0000_0010, 32'hAA22_3344);
    add_w(32'hBFAF_1234, 32'h1234_5678, 4'hF);
    add_r(32'hBFAF_1234, 32'h0000_0000);
    add_w(32'h0000_0080, 32'hFFFF_FFFF, 4'hF);
    add_w(32'h0000_0080, 32'h0102_0304, 4'h5);
    add_r(32'h0000_0080, 32'hFF02_FF04);
    add_r(32'hBFAF_E004, 32'h0000_0000);
    add_w(32'hBFAF_E004, 32'h0000_0055, 4'hF);
`ifdef DATA_SRAM_RESP_TIMER_IRQ_EN
    add_r(32'hBFAF_E004, 32'h0000_0055);
`else
    add_r(32'hBFAF_E004, 32'h0000_0000);
`endif
    add_r(32'h0000_0040, 32'hDEAD_BEEF);

    foreach (vecs[i]) drive(vecs[i]);
    idle();

    // dm holds across idle cycles and writes
    repeat (2) @(negedge clk);
    check("dm_hold_idle", dm, 32'hDEAD_BEEF);
    @(negedge clk);
    dce   = 1'b1;
    we    = 4'hF;
    daddr = 32'h0000_0044;
    din   = 32'h5555_5555;
    idle();
    #1;
    check("dm_hold_write", dm, 32'hDEAD_BEEF);
    check("led_value", {16'd0, led}, 32'h0000_A5A5);

    // timer interrupt: COMPARE=100, COUNTER=90, rise 11 edges later
    mmio_write(16'hE000, 32'd1000);
    mmio_write(16'hE004, 32'd100);
    mmio_write(16'hE000, 32'd90);
    idle();
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk);
      #1;
`ifdef DATA_SRAM_RESP_TIMER_IRQ_EN
      irq_exp = (k >= 11);
`else
      irq_exp = 1'b0;
`endif
      if (k >= 9) check($sformatf("timer_int_k%0d", k), {31'd0, timer_int}, {31'd0, irq_exp});
    end
    mmio_write(16'hE004, 32'd0);
    idle();
    #1;
    check("timer_int_clear", {31'd0, timer_int}, 32'd0);

    // reset during a pending read
    @(negedge clk);
    dce       = 1'b1;
    we        = 4'h0;
    daddr     = 32'h0000_0040;
    sb_expect = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midreset_dm_async", dm, 32'd0);
    @(posedge clk);
    #1;
    check("midreset_dm_edge", dm, 32'd0);
    check("midreset_led", {16'd0, led}, 32'd0);
    idle();
    rst_n = 1'b1;
    vecs.delete();
    add_r(32'h0000_0010, 32'hAA22_3344);
    add_r(32'h0000_0040, 32'hDEAD_BEEF);
    foreach (vecs[i]) drive(vecs[i]);
    idle();

    repeat (3) @(negedge clk);
    check("sb_queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
